// File: rtl/elink_tx_arbiter_if.sv
// Bundle of the arbiter's requester-side and serializer-side signals.
// The arbiter attaches through the slave modport.
`default_nettype none

interface elink_tx_arbiter_if;
  logic       tx_tick;
  logic [7:0] Kchar_comma;
  logic [3:0] req;
  logic [9:0] data_tra_in0;
  logic [9:0] data_tra_in1;
  logic [9:0] data_tra_in2;
  logic [9:0] data_tra_in3;
  logic [3:0] last;
  logic [3:0] buffer_en;
  logic [3:0] ack;
  logic [9:0] data_tra_out;
  logic       busy;
  logic       frame_abort;

  modport master (
    output tx_tick, Kchar_comma, req, last,
    output data_tra_in0, data_tra_in1, data_tra_in2, data_tra_in3,
    input  buffer_en, ack, data_tra_out, busy, frame_abort
  );

  modport slave (
    input  tx_tick, Kchar_comma, req, last,
    input  data_tra_in0, data_tra_in1, data_tra_in2, data_tra_in3,
    output buffer_en, ack, data_tra_out, busy, frame_abort
  );
endinterface

`default_nettype wire

// File: rtl/elink_tx_arbiter.sv
// Round-robin four-requester frame arbiter feeding one elink serializer,
// with comma fill while idle and an enforced comma gap between frames.
`default_nettype none

module elink_tx_arbiter #(
  parameter int MAX_FRAME_WORDS = 16,
  parameter int IDLE_GAP        = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  elink_tx_arbiter_if.slave bus
);

  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_GRANT     = 2'd1;
  localparam logic [1:0] c_GAP       = 2'd2;
  localparam logic [7:0] c_MAX_WORDS = 8'(MAX_FRAME_WORDS);
  localparam logic [3:0] c_GAP_TICKS = 4'(IDLE_GAP);
  localparam logic [1:0] c_REL_STATE = (IDLE_GAP == 0) ? c_IDLE : c_GAP;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_buffer_en;
  logic [3:0] w_buffer_en_nxt;
  logic [3:0] r_ack;
  logic [3:0] w_ack_nxt;
  logic       r_abort;
  logic       w_abort_nxt;
  logic [9:0] r_data;
  logic [9:0] w_data_nxt;
  logic [7:0] r_word_cnt;
  logic [7:0] w_word_cnt_nxt;
  logic [3:0] r_gap_cnt;
  logic [3:0] w_gap_cnt_nxt;
  logic [1:0] r_last_grant;
  logic [1:0] w_last_grant_nxt;
  logic [1:0] r_gnt_idx;
  logic [1:0] w_gnt_idx_nxt;

  logic [9:0] w_comma;
  logic [1:0] w_sel;
  logic       w_any_req;
  logic       w_gnt_req;
  logic       w_gnt_last;
  logic [9:0] w_gnt_data;
  logic [7:0] w_word_inc;
  logic [3:0] w_gap_inc;
  logic       w_frame_end;

  assign w_comma     = {2'b11, bus.Kchar_comma};
  assign w_any_req   = |bus.req;
  assign w_gnt_req   = bus.req[r_gnt_idx];
  assign w_gnt_last  = bus.last[r_gnt_idx];
  assign w_word_inc  = r_word_cnt + 8'd1;
  assign w_gap_inc   = r_gap_cnt + 4'd1;
  assign w_frame_end = w_gnt_last || (w_word_inc == c_MAX_WORDS);

  // Search starts one past the previous winner; offset 4 wraps back onto it.
  always_comb begin
    logic       v_found;
    logic [1:0] v_idx;
    w_sel   = r_last_grant;
    v_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      v_idx = r_last_grant + 2'(k);
      if (!v_found && bus.req[v_idx]) begin
        w_sel   = v_idx;
        v_found = 1'b1;
      end
    end
  end

  always_comb begin
    case (r_gnt_idx)
      2'd0:    w_gnt_data = bus.data_tra_in0;
      2'd1:    w_gnt_data = bus.data_tra_in1;
      2'd2:    w_gnt_data = bus.data_tra_in2;
      default: w_gnt_data = bus.data_tra_in3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = c_GRANT;
        end
      end
      c_GRANT: begin
        if (!w_gnt_req || (bus.tx_tick && w_frame_end)) begin
          w_state_nxt = c_REL_STATE;
        end
      end
      c_GAP: begin
        if (bus.tx_tick && (w_gap_inc == c_GAP_TICKS)) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // A dropped request wins over a tick in the same cycle: the word is not taken.
  always_comb begin
    w_buffer_en_nxt  = r_buffer_en;
    w_ack_nxt        = 4'b0000;
    w_abort_nxt      = 1'b0;
    w_data_nxt       = r_data;
    w_word_cnt_nxt   = r_word_cnt;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_last_grant_nxt = r_last_grant;
    w_gnt_idx_nxt    = r_gnt_idx;
    case (r_state)
      c_IDLE: begin
        if (bus.tx_tick) begin
          w_data_nxt = w_comma;
        end
        if (w_any_req) begin
          w_buffer_en_nxt  = 4'b0001 << w_sel;
          w_last_grant_nxt = w_sel;
          w_gnt_idx_nxt    = w_sel;
          w_word_cnt_nxt   = 8'd0;
        end
      end
      c_GRANT: begin
        if (!w_gnt_req) begin
          w_buffer_en_nxt = 4'b0000;
          w_abort_nxt     = 1'b1;
          w_gap_cnt_nxt   = 4'd0;
          if (bus.tx_tick) begin
            w_data_nxt = w_comma;
          end
        end else if (bus.tx_tick) begin
          w_data_nxt     = w_gnt_data;
          w_ack_nxt      = 4'b0001 << r_gnt_idx;
          w_word_cnt_nxt = w_word_inc;
          if (w_frame_end) begin
            w_buffer_en_nxt = 4'b0000;
            w_gap_cnt_nxt   = 4'd0;
            w_abort_nxt     = !w_gnt_last;
          end
        end
      end
      c_GAP: begin
        if (bus.tx_tick) begin
          w_data_nxt    = w_comma;
          w_gap_cnt_nxt = w_gap_inc;
        end
      end
      default: begin
        w_buffer_en_nxt = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buffer_en  <= 4'b0000;
      r_ack        <= 4'b0000;
      r_abort      <= 1'b0;
      r_data       <= w_comma;
      r_word_cnt   <= 8'd0;
      r_gap_cnt    <= 4'd0;
      r_last_grant <= 2'd3;
      r_gnt_idx    <= 2'd0;
    end else begin
      r_buffer_en  <= w_buffer_en_nxt;
      r_ack        <= w_ack_nxt;
      r_abort      <= w_abort_nxt;
      r_data       <= w_data_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_gnt_idx    <= w_gnt_idx_nxt;
    end
  end

  assign bus.buffer_en    = r_buffer_en;
  assign bus.ack          = r_ack;
  assign bus.frame_abort  = r_abort;
  assign bus.data_tra_out = r_data;
  assign bus.busy         = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_elink_tx_arbiter.sv
// Randomized and directed bench for elink_tx_arbiter against a frame-level
// reference model of grants, words, aborts and comma gaps.
`default_nettype none

module tb_elink_tx_arbiter;
  localparam int MAXW = 16;
  localparam int GAPW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  elink_tx_arbiter_if u_if();

  elink_tx_arbiter #(.MAX_FRAME_WORDS(MAXW), .IDLE_GAP(GAPW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0] din [4];
  int         n_ack [4];
  int         n_abort;
  int         grant_q [$];
  logic [3:0] prev_ben;

  // Model: current owner (-1 none), commas still owed before arbitration
  int         m_owner;
  int         m_gap_left;
  int         m_words;
  int         m_last;
  logic [9:0] m_out;
  logic [3:0] m_ack;
  logic       m_abort;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void release_frame(input logic abort);
    m_owner    = -1;
    m_gap_left = GAPW;
    m_abort    = abort;
  endfunction

  function automatic void model(input logic r, input logic t, input logic [3:0] rq,
                                input logic [3:0] ls, input logic [7:0] kc);
    logic [9:0] comma;
    int         n;
    comma   = {2'b11, kc};
    m_ack   = 4'b0;
    m_abort = 1'b0;
    if (r) begin
      m_owner = -1; m_gap_left = 0; m_words = 0; m_last = 3; m_out = comma;
      return;
    end
    if (m_owner >= 0) begin
      n = m_owner;
      if (!rq[n]) begin
        if (t) m_out = comma;
        release_frame(1'b1);
      end else if (t) begin
        m_out    = din[n];
        m_ack[n] = 1'b1;
        m_words  = m_words + 1;
        if (ls[n])                release_frame(1'b0);
        else if (m_words == MAXW) release_frame(1'b1);
      end
    end else if (m_gap_left > 0) begin
      if (t) begin
        m_out      = comma;
        m_gap_left = m_gap_left - 1;
      end
    end else begin
      if (t) m_out = comma;
      for (int k = 1; k <= 4; k++) begin
        n = (m_last + k) % 4;
        if (m_owner < 0 && rq[n]) begin
          m_owner = n;
          m_last  = n;
          m_words = 0;
        end
      end
    end
  endfunction

  task automatic step(input logic r, input logic t, input logic [3:0] rq, input logic [3:0] ls);
    logic [3:0] exp_ben;
    rst                = r;
    u_if.tx_tick       = t;
    u_if.req           = rq;
    u_if.last          = ls;
    u_if.data_tra_in0  = din[0];
    u_if.data_tra_in1  = din[1];
    u_if.data_tra_in2  = din[2];
    u_if.data_tra_in3  = din[3];
    prev_ben           = u_if.buffer_en;
    model(r, t, rq, ls, u_if.Kchar_comma);
    @(posedge clk);
    #1;
    exp_ben = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("buffer_en",    32'(u_if.buffer_en),    32'(exp_ben));
    chk("ack",          32'(u_if.ack),          32'(m_ack));
    chk("data_tra_out", 32'(u_if.data_tra_out), 32'(m_out));
    chk("busy",         32'(u_if.busy),         32'((m_owner >= 0) || (m_gap_left > 0)));
    chk("frame_abort",  32'(u_if.frame_abort),  32'(m_abort));
    if (u_if.frame_abort === 1'b1) n_abort++;
    for (int i = 0; i < 4; i++) begin
      if (u_if.ack[i] === 1'b1) n_ack[i]++;
      if (prev_ben == 4'b0 && u_if.buffer_en[i] === 1'b1) grant_q.push_back(i);
    end
  endtask

  task automatic clear_stats();
    n_abort = 0;
    for (int i = 0; i < 4; i++) n_ack[i] = 0;
    grant_q.delete();
  endtask

  initial begin
    logic [3:0] rq;
    u_if.Kchar_comma = 8'hBC;
    for (int i = 0; i < 4; i++) din[i] = 10'h0;
    m_owner = -1; m_gap_left = 0; m_words = 0; m_last = 3; m_out = '0;
    clear_stats();

    // Idle comma fill after reset
    step(1'b1, 1'b0, 4'b0, 4'b0);
    step(1'b1, 1'b1, 4'b0, 4'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 4'b0, 4'b0);
      chk("idle_comma", 32'(u_if.data_tra_out), 32'h3BC);
    end

    // Three-word frame from requester 0
    clear_stats();
    step(1'b0, 1'b1, 4'b0001, 4'b0);
    chk("grant0", 32'(u_if.buffer_en), 32'h1);
    din[0] = 10'h101; step(1'b0, 1'b1, 4'b0001, 4'b0);
    chk("word1", 32'(u_if.data_tra_out), 32'h101);
    din[0] = 10'h102; step(1'b0, 1'b1, 4'b0001, 4'b0);
    din[0] = 10'h303; step(1'b0, 1'b1, 4'b0001, 4'b0001);
    chk("word3", 32'(u_if.data_tra_out), 32'h303);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0, 4'b0);
    chk("frame3_acks", 32'(n_ack[0]), 32'd3);
    chk("frame3_abort", 32'(n_abort), 32'd0);

    // All requesting, single-word frames: rotation
    step(1'b1, 1'b0, 4'b0, 4'b0);
    clear_stats();
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 4'hF, 4'hF);
    chk("rr_count", 32'(grant_q.size() >= 5), 32'd1);
    if (grant_q.size() >= 5) begin
      chk("rr_0", 32'(grant_q[0]), 32'd0);
      chk("rr_1", 32'(grant_q[1]), 32'd1);
      chk("rr_2", 32'(grant_q[2]), 32'd2);
      chk("rr_3", 32'(grant_q[3]), 32'd3);
      chk("rr_4", 32'(grant_q[4]), 32'd0);
    end

    // Max-length forced release on requester 2
    step(1'b1, 1'b0, 4'b0, 4'b0);
    clear_stats();
    for (int i = 0; i < MAXW + 1; i++) begin
      din[2] = 10'($urandom);
      step(1'b0, 1'b1, 4'b0100, 4'b0);
    end
    chk("max_acks", 32'(n_ack[2]), 32'(MAXW));
    chk("max_abort", 32'(n_abort), 32'd1);
    chk("max_ben", 32'(u_if.buffer_en), 32'd0);
    chk("max_gap_busy", 32'(u_if.busy), 32'd1);

    // Requester 1 withdraws after two words
    step(1'b1, 1'b0, 4'b0, 4'b0);
    clear_stats();
    step(1'b0, 1'b1, 4'b0010, 4'b0);
    step(1'b0, 1'b1, 4'b0010, 4'b0);
    step(1'b0, 1'b1, 4'b0010, 4'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0, 4'b0);
    chk("drop_acks", 32'(n_ack[1]), 32'd2);
    chk("drop_abort", 32'(n_abort), 32'd1);

    // Reset in the middle of a frame
    step(1'b1, 1'b0, 4'b0, 4'b0);
    step(1'b0, 1'b1, 4'b0001, 4'b0);
    step(1'b0, 1'b1, 4'b0001, 4'b0);
    step(1'b1, 1'b1, 4'b0001, 4'b0);
    chk("rst_mid_out", 32'(u_if.data_tra_out), 32'h3BC);
    chk("rst_mid_ben", 32'(u_if.buffer_en), 32'd0);

    // Random traffic
    rq = 4'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) rq = 4'($urandom);
      if ($urandom_range(15) == 0) u_if.Kchar_comma = 8'($urandom);
      for (int j = 0; j < 4; j++) din[j] = 10'($urandom);
      step(($urandom_range(399) == 0), 1'($urandom),
           rq, {($urandom_range(7) == 0), ($urandom_range(7) == 0),
                ($urandom_range(7) == 0), ($urandom_range(7) == 0)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
